subq_pipe: RTL and testbench
============================

SUBQ_PIPE -- requirements
Module: subq_pipe

Interface
REQ-001 Parameter: W, default 16, total word width; bit W-1 is sign, bits W-2:0 are magnitude (sign-magnitude fixed point, same format as the GRU datapath adder).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand pair x,y presented.
REQ-005 in_ready  output  1  block accepts the pair this cycle.
REQ-006 x  input  W  minuend, sign-magnitude.
REQ-007 y  input  W  subtrahend, sign-magnitude.
REQ-008 out_valid  output  1  diff and ovf hold a result.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 diff  output  W  x - y, sign-magnitude.
REQ-011 ovf  output  1  result saturated; qualified by out_valid.

Function
REQ-012 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-013 Two pipeline stages, S1 and S2, each with a valid bit; latency from input transfer to out_valid is exactly 2 cycles when not stalled.
REQ-014 S1 converts both operands to (W+1)-bit two's complement (negate magnitude when sign=1) and registers x_tc - y_tc at W+2 bits, with no truncation.
REQ-015 S2 converts the S1 difference back to sign-magnitude and registers diff and ovf; S2 drives the outputs directly from its registers.
REQ-016 Negative zero (sign=1, magnitude 0) on either input is treated as zero.
REQ-017 A zero result is always emitted as all-zeros, never as negative zero.
REQ-018 If the result magnitude exceeds 2^(W-1)-1, diff is the correct sign with magnitude all-ones, and ovf=1.
REQ-019 Otherwise ovf=0.
REQ-020 S2 loads when S1 is valid and S2 is empty or transferring out this cycle.
REQ-021 S1 loads when S1 is empty or moving into S2 this cycle.
REQ-022 in_ready equals the S1 load condition: combinational from out_ready and the valid bits, with no dependency on in_valid.
REQ-023 Under backpressure (out_ready=0), a full pipeline holds both stages unchanged, diff and ovf stay stable, and in_ready=0.
REQ-024 Sustained in_valid=1 and out_ready=1 gives throughput of one result per cycle with no bubbles.
REQ-025 Simultaneous input and output transfer in the same cycle is legal and loses no data.
REQ-026 Results leave in input order; no result is dropped or duplicated.

Reset
REQ-027 While rst=1 at a clock edge, the S1 and S2 valid bits clear, so out_valid=0, diff=0 and ovf=0 on the next cycle.
REQ-028 While rst=1, in_ready=0, and any operand presented is discarded.
REQ-029 Reset mid-operation discards in-flight results; after rst deasserts, in_ready=1 on the first cycle.
REQ-030 Data registers other than the outputs need no reset; outputs are reset to zero.

Structure
REQ-031 A shared fixed-point package holds:
  - the W default;
  - the sign-magnitude/two's-complement conversion functions;
  - the saturated-magnitude constant;
  - the negative-zero constant.
REQ-032 One sub-module, sm_tc_conv (combinational sign-magnitude to/from two's complement, with zero normalization), is instantiated in both S1 and S2.
REQ-033 The existing adder is not reused; subq_pipe is stand-alone.

Verification
REQ-034 x=0x0005, y=0x0003 -> diff=0x0002, ovf=0, out_valid 2 cycles after acceptance.
REQ-035 x=0x0003, y=0x0005 -> diff=0x8002; x=0x8004, y=0x8004 -> diff=0x0000; x=0x8000, y=0x0000 -> diff=0x0000.
REQ-036 x=0x7FFF, y=0x8001 -> diff=0x7FFF, ovf=1; x=0x8010, y=0x7FF0 -> diff=0xFFFF, ovf=1.
REQ-037 Backpressure: stream of 8 pairs, out_ready low for 5 cycles mid-stream -> in_ready=0 while full, outputs stable, all 8 results in order, none lost.
REQ-038 Back-to-back: 16 pairs with in_valid=1 and out_ready=1 throughout -> 16 consecutive out_valid cycles; results match a reference model.
REQ-039 Reset with S1 and S2 both full -> next cycle out_valid=0, diff=0, ovf=0; a new pair issued after reset emerges correctly 2 cycles later.

Source files
------------

// File: rtl/subq_pipe_pkg.sv
// Shared sign-magnitude fixed-point definitions for the subtract pipeline.
// Conversions work on a wide 64-bit carrier and take the live width as an argument.
package subq_pipe_pkg;

  localparam int W_DEF = 16;
  localparam int MAXW  = 64;

  localparam logic [W_DEF-2:0] SAT_MAG  = {(W_DEF-1){1'b1}};
  localparam logic [W_DEF-1:0] NEG_ZERO = {1'b1, {(W_DEF-1){1'b0}}};

  typedef enum logic {
    CONV_SM2TC = 1'b0,
    CONV_TC2SM = 1'b1
  } conv_mode_e;

  // Sign-magnitude of width w -> two's complement sign-extended to MAXW; -0 maps to 0.
  function automatic logic [MAXW-1:0] sm_to_tc(input logic [MAXW-1:0] sm, input int w);
    logic [MAXW-1:0] mag;
    mag = sm & ((64'd1 << (w - 1)) - 64'd1);
    if (sm[w-1] && (mag != 64'd0)) begin
      sm_to_tc = ~mag + 64'd1;
    end else begin
      sm_to_tc = mag;
    end
  endfunction

  // Two's complement (MAXW, sign-extended) -> {ovf, sign-magnitude of width w}, saturating.
  function automatic logic [MAXW:0] tc_to_sm(input logic [MAXW-1:0] tc, input int w);
    logic [MAXW-1:0] mag;
    logic [MAXW-1:0] max_mag;
    logic            neg;
    logic            sat;
    neg     = tc[MAXW-1];
    mag     = neg ? (~tc + 64'd1) : tc;
    max_mag = (64'd1 << (w - 1)) - 64'd1;
    sat     = (mag > max_mag);
    if (sat) begin
      mag = max_mag;
    end
    if (mag == 64'd0) begin
      neg = 1'b0;
    end
    tc_to_sm = {sat, (neg ? (mag | (64'd1 << (w - 1))) : mag)};
  endfunction

endpackage

// File: rtl/sm_tc_conv.sv
// Combinational sign-magnitude <-> two's complement converter with zero normalization.
// CONV_SM2TC: din[W-1:0] is SM, dout is (W+2)-bit TC. CONV_TC2SM: din is TC, dout[W-1:0] is SM.
module sm_tc_conv
  import subq_pipe_pkg::*;
#(
  parameter int         W    = W_DEF,
  parameter conv_mode_e MODE = CONV_SM2TC
) (
  input  logic [W+1:0] din,
  output logic [W+1:0] dout,
  output logic         ovf
);

  if (MODE == CONV_SM2TC) begin : g_sm2tc
    logic [MAXW-1:0] tc_s;
    logic            unused_s;

    assign tc_s     = sm_to_tc({{(MAXW-W){1'b0}}, din[W-1:0]}, W);
    assign dout     = tc_s[W+1:0];
    assign ovf      = 1'b0;
    assign unused_s = ^{tc_s[MAXW-1:W+2], din[W+1:W]};
  end else begin : g_tc2sm
    logic [MAXW:0] res_s;
    logic          unused_s;

    assign res_s    = tc_to_sm({{(MAXW-W-2){din[W+1]}}, din}, W);
    assign dout     = {2'b00, res_s[W-1:0]};
    assign ovf      = res_s[MAXW];
    assign unused_s = ^res_s[MAXW-1:W];
  end

endmodule

// File: rtl/subq_pipe.sv
// Two-stage sign-magnitude subtractor (diff = x - y) with valid/ready handshakes.
// S1 holds the exact (W+2)-bit two's complement difference; S2 holds the saturated SM result.
module subq_pipe
  import subq_pipe_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         ovf
);

  logic [W+1:0] x_tc_s;
  logic [W+1:0] y_tc_s;
  logic [W+1:0] d_sm_s;
  logic         d_ovf_s;
  logic         unused_x_ovf_s;
  logic         unused_y_ovf_s;
  logic         unused_hi_s;

  logic         s1_valid_r;
  logic [W+1:0] s1_diff_r;
  logic         s2_valid_r;
  logic [W-1:0] diff_r;
  logic         ovf_r;

  logic         s1_load_s;
  logic         s2_load_s;

  sm_tc_conv #(.W(W), .MODE(CONV_SM2TC)) u_conv_x (
    .din  ({2'b00, x}),
    .dout (x_tc_s),
    .ovf  (unused_x_ovf_s)
  );

  sm_tc_conv #(.W(W), .MODE(CONV_SM2TC)) u_conv_y (
    .din  ({2'b00, y}),
    .dout (y_tc_s),
    .ovf  (unused_y_ovf_s)
  );

  sm_tc_conv #(.W(W), .MODE(CONV_TC2SM)) u_conv_d (
    .din  (s1_diff_r),
    .dout (d_sm_s),
    .ovf  (d_ovf_s)
  );

  assign unused_hi_s = ^d_sm_s[W+1:W];

  assign s2_load_s = s1_valid_r && (!s2_valid_r || out_ready);
  assign s1_load_s = !rst && (!s1_valid_r || s2_load_s);
  assign in_ready  = s1_load_s;

  // S1: capture the exact difference; valid follows in_valid whenever the stage may load.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
    end else if (s1_load_s) begin
      s1_valid_r <= in_valid;
    end
    if (s1_load_s && in_valid) begin
      s1_diff_r <= x_tc_s - y_tc_s;
    end
  end

  // S2: output register; empties on an output transfer with nothing behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      diff_r     <= {W{1'b0}};
      ovf_r      <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r <= 1'b1;
      diff_r     <= d_sm_s[W-1:0];
      ovf_r      <= d_ovf_s;
    end else if (out_ready) begin
      s2_valid_r <= 1'b0;
    end
  end

  assign out_valid = s2_valid_r;
  assign diff      = diff_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_subq_pipe.sv
// Randomized self-checking bench for subq_pipe against a queue-based arithmetic reference.
module tb_subq_pipe;
  import subq_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        ovf;

  subq_pipe #(.W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        o;
    int          acc;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          n_out = 0;
  logic        after_rst = 1'b0;
  logic        hold_prev = 1'b0;
  logic [15:0] hold_diff;
  logic        hold_ovf;
  logic        dir_en = 1'b0;
  logic [15:0] dir_d;
  logic        dir_o;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: plain integer subtraction, then saturate to 15-bit magnitude; zero is never negative.
  function automatic logic [16:0] ref_sub(input logic [15:0] a, input logic [15:0] b);
    int   av, bv, r, m;
    logic neg, sat;
    av = int'(a[14:0]);
    bv = int'(b[14:0]);
    if (a[15]) av = -av;
    if (b[15]) bv = -bv;
    r   = av - bv;
    neg = (r < 0);
    m   = neg ? -r : r;
    sat = (m > 32767);
    if (sat) m = 32767;
    if (m == 0) neg = 1'b0;
    return {sat, neg, m[14:0]};
  endfunction

  function automatic logic [15:0] rnd_op();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 3))
      0: v = v;
      1: v = {v[15], 11'h7FF, v[3:0]};
      2: v = {v[15], 15'd0};
      default: v = {v[15], 11'd0, v[3:0]};
    endcase
    return v;
  endfunction

  task automatic step(input logic iv, input logic [15:0] xi, input logic [15:0] yi,
                      input logic ordy, output logic acc);
    exp_t        e;
    logic [16:0] r;
    in_valid  = iv;
    x         = xi;
    y         = yi;
    out_ready = ordy;
    @(negedge clk);
    check("in_ready", 32'(in_ready), 32'(!rst && !(q.size() == 2 && !ordy)));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0 && (cyc - q[0].acc) >= 2));
    if (after_rst) begin
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      after_rst = 1'b0;
    end
    if (hold_prev) begin
      check("hold_diff", 32'(diff), 32'(hold_diff));
      check("hold_ovf", 32'(ovf), 32'(hold_ovf));
    end
    hold_prev = out_valid && !ordy;
    hold_diff = diff;
    hold_ovf  = ovf;
    if (out_valid && ordy && q.size() > 0) begin
      e = q.pop_front();
      check("diff", 32'(diff), 32'(e.d));
      check("ovf", 32'(ovf), 32'(e.o));
      n_out++;
    end
    acc = iv && in_ready;
    if (acc) begin
      r     = ref_sub(xi, yi);
      e.d   = dir_en ? dir_d : r[15:0];
      e.o   = dir_en ? dir_o : r[16];
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      q.delete();
      after_rst = 1'b1;
      hold_prev = 1'b0;
    end
  endtask

  task automatic drain(input string tag);
    logic a;
    for (int k = 0; k < 40 && q.size() != 0; k++) step(1'b0, 16'd0, 16'd0, 1'b1, a);
    check(tag, 32'(q.size()), 32'd0);
  endtask

  logic [15:0] dx[7];
  logic [15:0] dy[7];
  logic [15:0] dd[7];
  logic        dov[7];

  initial begin
    logic a;
    int   sent, base, accn;
    logic seen_full;
    logic [15:0] xs, ys;

    dx[0] = 16'h0005; dy[0] = 16'h0003; dd[0] = 16'h0002; dov[0] = 1'b0;
    dx[1] = 16'h0003; dy[1] = 16'h0005; dd[1] = 16'h8002; dov[1] = 1'b0;
    dx[2] = 16'h8004; dy[2] = 16'h8004; dd[2] = 16'h0000; dov[2] = 1'b0;
    dx[3] = NEG_ZERO; dy[3] = 16'h0000; dd[3] = 16'h0000; dov[3] = 1'b0;
    dx[4] = 16'h7FFF; dy[4] = 16'h8001; dd[4] = {1'b0, SAT_MAG}; dov[4] = 1'b1;
    dx[5] = 16'h8010; dy[5] = 16'h7FF0; dd[5] = 16'hFFFF; dov[5] = 1'b1;
    dx[6] = 16'h0000; dy[6] = NEG_ZERO; dd[6] = 16'h0000; dov[6] = 1'b0;

    rst = 1'b1; in_valid = 1'b0; x = 16'd0; y = 16'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_diff", 32'(diff), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("post_reset_in_ready", 32'(in_ready), 32'd1);

    // Directed corner vectors, each sent alone to expose the two-cycle latency.
    dir_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      dir_d = dd[i];
      dir_o = dov[i];
      step(1'b1, dx[i], dy[i], 1'b1, a);
      check("dir_accept", 32'(a), 32'd1);
      dir_en = 1'b1;
      step(1'b0, 16'd0, 16'd0, 1'b1, a);
      step(1'b0, 16'd0, 16'd0, 1'b1, a);
      step(1'b0, 16'd0, 16'd0, 1'b1, a);
    end
    dir_en = 1'b0;
    check("dir_count", 32'(n_out), 32'd7);

    // Back-to-back stream of 16 pairs.
    base = n_out;
    accn = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, rnd_op(), rnd_op(), 1'b1, a);
      if (a) accn++;
    end
    step(1'b0, 16'd0, 16'd0, 1'b1, a);
    step(1'b0, 16'd0, 16'd0, 1'b1, a);
    check("b2b_accepted", 32'(accn), 32'd16);
    check("b2b_outputs", 32'(n_out - base), 32'd16);

    // 8 pairs with a 5-cycle output stall mid-stream.
    sent = 0;
    seen_full = 1'b0;
    xs = rnd_op();
    ys = rnd_op();
    for (int k = 0; k < 60 && (sent < 8 || q.size() != 0); k++) begin
      step(sent < 8, xs, ys, !(k >= 3 && k < 8), a);
      if (k >= 3 && k < 8 && sent < 8 && !a) seen_full = 1'b1;
      if (a) begin
        sent++;
        xs = rnd_op();
        ys = rnd_op();
      end
    end
    check("bp_sent", 32'(sent), 32'd8);
    check("bp_drained", 32'(q.size()), 32'd0);
    check("bp_full_seen", 32'(seen_full), 32'd1);

    // Randomized traffic on both handshakes.
    for (int k = 0; k < 300; k++) begin
      step($urandom_range(0, 3) != 0, rnd_op(), rnd_op(), $urandom_range(0, 3) != 0, a);
    end
    drain("rand_drain");

    // Reset with both stages full, then one fresh pair.
    step(1'b1, rnd_op(), rnd_op(), 1'b0, a);
    step(1'b1, rnd_op(), rnd_op(), 1'b0, a);
    step(1'b1, rnd_op(), rnd_op(), 1'b0, a);
    check("full_before_rst", 32'(q.size()), 32'd2);
    rst = 1'b1;
    step(1'b1, rnd_op(), rnd_op(), 1'b1, a);
    rst = 1'b0;
    base = n_out;
    step(1'b1, 16'h0100, 16'h8023, 1'b1, a);
    check("rst_new_accept", 32'(a), 32'd1);
    drain("rst_drain");
    check("rst_new_out", 32'(n_out - base), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
